// File: rtl/clock_set_controller.sv
// Time-set sequencer: freezes the clock, edits hour then minute, commits with a one-cycle load strobe.
// All outputs registered (one cycle after the causing input); no backpressure, buttons are sampled every cycle.
module clock_set_controller #(
  parameter int BLINK_DIV    = 25000000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic       run_en,
  output logic       load,
  output logic [4:0] load_hour,
  output logic [5:0] load_min,
  output logic       blink_hr,
  output logic       blink_min
);

  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {RUN, EDIT_HR, EDIT_MIN, COMMIT} state_t;

  state_t        state, nextState;
  logic [4:0]    editHr, editHrNext;
  logic [5:0]    editMin, editMinNext;
  logic          nextPrev, incPrev;
  logic [RW-1:0] repCnt, repCntNext;
  logic [BW-1:0] blinkCnt, blinkCntNext;
  logic          phase, phaseNext;
  logic          nextRise, incRise, repHit, doInc;

  assign nextRise = btn_next & ~nextPrev;
  assign incRise  = btn_inc & ~incPrev;

  always_comb begin
    nextState    = state;
    editHrNext   = editHr;
    editMinNext  = editMin;
    repCntNext   = repCnt;
    blinkCntNext = blinkCnt;
    phaseNext    = phase;
    repHit       = btn_inc && (repCnt == REP_LAST);
    doInc        = 1'b0;
    case (state)
      RUN: begin
        repCntNext = '0;
        if (set_en) begin
          nextState    = EDIT_HR;
          editHrNext   = cur_hour;
          editMinNext  = cur_min;
          blinkCntNext = '0;
          phaseNext    = 1'b0;
        end
      end
      EDIT_HR, EDIT_MIN: begin
        // Leaving set mode outranks any button activity in the same cycle.
        if (!set_en) begin
          nextState = COMMIT;
        end else begin
          if (nextRise) begin
            nextState  = (state == EDIT_HR) ? EDIT_MIN : EDIT_HR;
            repCntNext = '0;
          end else begin
            doInc = incRise || repHit;
            if (!btn_inc)    repCntNext = '0;
            else if (repHit) repCntNext = REP_RELOAD;
            else             repCntNext = repCnt + 1'b1;
            if (doInc && state == EDIT_HR)
              editHrNext = (editHr == 5'd23) ? 5'd0 : editHr + 5'd1;
            else if (doInc)
              editMinNext = (editMin == 6'd59) ? 6'd0 : editMin + 6'd1;
          end
          // An increment restarts the blink period with the digits lit.
          if (doInc) begin
            blinkCntNext = '0;
            phaseNext    = 1'b0;
          end else if (blinkCnt == BLINK_LAST) begin
            blinkCntNext = '0;
            phaseNext    = ~phase;
          end else begin
            blinkCntNext = blinkCnt + 1'b1;
          end
        end
      end
      COMMIT: begin
        nextState  = RUN;
        repCntNext = '0;
      end
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      editHr    <= '0;
      editMin   <= '0;
      nextPrev  <= 1'b0;
      incPrev   <= 1'b0;
      repCnt    <= '0;
      blinkCnt  <= '0;
      phase     <= 1'b0;
      run_en    <= 1'b1;
      load      <= 1'b0;
      load_hour <= '0;
      load_min  <= '0;
      blink_hr  <= 1'b0;
      blink_min <= 1'b0;
    end else begin
      state     <= nextState;
      editHr    <= editHrNext;
      editMin   <= editMinNext;
      nextPrev  <= btn_next;
      incPrev   <= btn_inc;
      repCnt    <= repCntNext;
      blinkCnt  <= blinkCntNext;
      phase     <= phaseNext;
      // COMMIT keeps the counters frozen so no tick races the load.
      run_en    <= (nextState == RUN);
      load      <= (nextState == COMMIT);
      if (nextState == COMMIT) begin
        load_hour <= editHr;
        load_min  <= editMin;
      end
      blink_hr  <= (nextState == EDIT_HR) && phaseNext;
      blink_min <= (nextState == EDIT_MIN) && phaseNext;
    end
  end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
Time-setting sequencer for the 24-hour digital clock datapath. It freezes the running hour/minute/second counters when set mode is entered and lets the user edit hours, then minutes, with NEXT and INC buttons (with auto-repeat). On leaving set mode it issues a single load strobe that writes the edited time back into the counters. It also drives blink enables for the digit pair being edited.

Parameters:
BLINK_DIV, 25000000, clock cycles per blink half-period (50 MHz clk -> 1 Hz blink)
REPEAT_DELAY, 25000000, cycles INC must be held before auto-repeat starts
REPEAT_RATE, 5000000, cycles between auto-repeat increments once repeating

Ports:
clk  in  1  system clock; sole clock domain
rst  in  1  synchronous reset, active-high
set_en  in  1  set-mode switch level; already synchronized upstream
btn_next  in  1  NEXT button level; already synchronized and debounced upstream
btn_inc  in  1  INC button level; already synchronized and debounced upstream
cur_hour  in  5  live hour counter value, 0..23
cur_min  in  6  live minute counter value, 0..59
run_en  out  1  1 = counters advance on the 1 s tick; 0 = counters frozen
load  out  1  single-cycle strobe; counters take load_hour/load_min, seconds cleared
load_hour  out  5  hour value to load
load_min  out  6  minute value to load
blink_hr  out  1  blank the hour digits when 1
blink_min  out  1  blank the minute digits when 1

Behaviour:
- All outputs are registered. Reset values: run_en=1, load=0, load_hour=0, load_min=0, blink_hr=0, blink_min=0. State=RUN. Edit registers, edge registers, repeat counter, blink counter and blink phase are all 0.
- Edge detection: registered copies of btn_next and btn_inc. A rise is input=1 while the previous sample was 0. Reset clears the previous samples to 0, so a button held through reset produces a rise on the first cycle after reset.
- FSM states: RUN, EDIT_HR, EDIT_MIN, COMMIT.
- RUN: run_en=1. If set_en=1 in cycle N, then at N+1: edit_hr<=cur_hour, edit_min<=cur_min, run_en=0, state=EDIT_HR, blink counter and blink phase cleared.
- EDIT_HR / EDIT_MIN:
  - A NEXT rise toggles between EDIT_HR and EDIT_MIN and clears the repeat counter.
  - An INC rise increments the active field in the next cycle.
  - NEXT has priority: if NEXT and INC rise in the same cycle, the INC is discarded.
- Wrap rules: hour 23 -> 0, minute 59 -> 0. Arithmetic is done in field width with an explicit compare, never modulo of an overflowed value.
- Auto-repeat:
  - While btn_inc stays 1, the repeat counter counts every cycle.
  - When it reaches REPEAT_DELAY, do one increment and reload the counter to REPEAT_DELAY-REPEAT_RATE, so subsequent increments occur every REPEAT_RATE cycles.
  - btn_inc=0 clears the counter.
- Blink:
  - The blink counter counts to BLINK_DIV-1, then wraps and toggles the phase.
  - blink_hr = (state==EDIT_HR) & phase; blink_min = (state==EDIT_MIN) & phase.
  - Both are 0 in RUN and COMMIT.
  - Any INC-triggered increment forces phase=0 and clears the blink counter, so the edited value stays visible.
- Exit:
  - set_en=0 in any EDIT state moves to COMMIT the next cycle. Exit takes priority over any button event in that same cycle.
  - In COMMIT: load=1 for exactly one cycle with load_hour=edit_hr and load_min=edit_min. The following cycle: state=RUN, run_en=1, load=0.
  - The downstream counter clears seconds on load.
- run_en stays 0 during the COMMIT cycle, so no tick can race the load.
- Reset mid-edit abandons the edit: no load pulse is produced, and the block returns to RUN with run_en=1.
- A set_en glitch of one cycle still produces a full RUN -> EDIT_HR -> COMMIT -> RUN sequence with the captured (unchanged) time loaded.
- load_hour/load_min hold their last values outside COMMIT.

Test Plan:
- Reset then idle 100 cycles -> run_en=1, load=0, blink_hr=blink_min=0 throughout.
- cur_hour=23, cur_min=59; raise set_en; one INC rise; NEXT rise; one INC rise; drop set_en -> single load pulse with load_hour=0, load_min=0; run_en=1 one cycle after the load.
- REPEAT_DELAY=10, REPEAT_RATE=3; in EDIT_MIN from 58, hold INC for 20 cycles -> minute sequence 59, 0, 1, 2, 3 with increments at held-cycles 1, 10, 13, 16, 19.
- NEXT and INC rise in the same cycle in EDIT_HR -> state becomes EDIT_MIN, edit_hr unchanged.
- BLINK_DIV=4, idle in EDIT_HR -> blink_hr toggles every 4 cycles, blink_min=0. An INC rise forces blink_hr=0 and restarts the period.
- Assert rst while in EDIT_MIN with the edit value changed -> no load pulse; outputs at reset values; run_en=1 the cycle after rst.
